data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter Mbit, default 32: data and address width in bits.
REQ-002 Parameter DEPTH, default 256: number of Mbit-wide storage words.
REQ-003 Parameter WAIT_CYCLES, default 2, legal range 0..15: wait states inserted before each response.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 req  input  1  initiator request strobe; sampled only in IDLE.
REQ-007 Adr  input  Mbit  byte address from initiator ALU.
REQ-008 wrtData  input  Mbit  write data.
REQ-009 mwr  input  1  memory write request qualifier.
REQ-010 moe  input  1  memory output-enable (read) qualifier.
REQ-011 rd  output  Mbit  read data returned to initiator.
REQ-012 ack  output  1  single-cycle completion pulse.
REQ-013 err  output  1  error flag; valid only while ack=1.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 In IDLE with req=1, the block SHALL latch Adr, wrtData, mwr and moe at the rising edge and leave IDLE; the initiator need not hold these inputs afterwards.
REQ-017 The next state after IDLE SHALL be WAIT when WAIT_CYCLES>0 and RESP when WAIT_CYCLES=0.
REQ-018 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter loaded on capture; it SHALL then enter RESP.
REQ-019 RESP SHALL last one cycle with ack=1 and SHALL always return to IDLE.
REQ-020 Latency: ack SHALL be high in cycle WAIT_CYCLES+1, where cycle 0 is the request-capture cycle; throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-021 req asserted outside IDLE SHALL be ignored; it SHALL not be queued.
REQ-022 Word index SHALL be Adr[log2(DEPTH)+1:2].
REQ-023 err SHALL be 1 in RESP when latched Adr[1:0]!=0 or when latched Adr>>2 >= DEPTH; an erroring access SHALL neither write storage nor update rd.
REQ-024 Write (mwr=1, no error): storage SHALL update at the rising edge that enters RESP; rd SHALL remain unchanged.
REQ-025 Read (moe=1, mwr=0, no error): rd SHALL present the addressed word while ack=1 and SHALL hold that value until the next successful read.
REQ-026 mwr=1 and moe=1 together SHALL be treated as a write only.
REQ-027 mwr=0 and moe=0 SHALL complete as a no-op with ack=1 and err=0.
REQ-028 A read of a word written by the immediately preceding access SHALL return the new data.

Reset
REQ-029 On reset=0, asynchronously: state SHALL be IDLE, ack=0, err=0, busy=0, rd=0, and the wait counter SHALL be 0.
REQ-030 Reset asserted mid-access SHALL abandon the access: no storage write and no ack after release.
REQ-031 Storage contents SHALL NOT be reset.

Configuration
REQ-032 With macro DMR_ACC_CNT_EN defined, the block SHALL add output acc_cnt [15:0], reset to 0, which increments on each ack with err=0 and saturates at 16'hFFFF.
REQ-033 With DMR_ACC_CNT_EN undefined, acc_cnt SHALL be absent and the block SHALL behave identically in all other respects.

Verification
REQ-034 WAIT_CYCLES=2: write Adr=0x10, wrtData=0xDEADBEEF, then read Adr=0x10 -> each ack is in cycle 3 after capture; the read gives rd=0xDEADBEEF and err=0.
REQ-035 Read Adr=0x13 -> ack=1, err=1, rd unchanged; a write to Adr=DEPTH*4 -> err=1 and no storage change.
REQ-036 req held high continuously across the read sequence to 0x0,0x4 -> exactly one ack per 4 cycles; no request is lost or duplicated beyond the IDLE sampling rule.
REQ-037 reset=0 pulsed during WAIT of a write to 0x20 (old value 0x1) -> ack never asserts, and a subsequent read of 0x20 returns 0x1.
REQ-038 WAIT_CYCLES=0 with mwr=moe=1 to 0x8, data 0x5 -> ack in cycle 1, rd unchanged, and a later read returns 0x5.
REQ-039 DMR_ACC_CNT_EN defined: 3 good accesses plus 1 misaligned access -> acc_cnt=3.

Source files
------------

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Single-port word memory behind a request/acknowledge handshake. A request
// seen in IDLE captures address, write data and the mwr/moe qualifiers, waits
// WAIT_CYCLES cycles, then spends one RESP cycle with ack=1. Misaligned or
// out-of-range addresses complete with err=1 and leave storage and rd alone.
//
// Optional feature: define DMR_ACC_CNT_EN to add the acc_cnt output, a
// saturating count of error-free completions.
//
// Parameters
//   Mbit        data/address width in bits
//   DEPTH       number of Mbit-wide storage words
//   WAIT_CYCLES wait states before each response (0..15)
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   req      request strobe, sampled only in IDLE
//   Adr      byte address
//   wrtData  write data
//   mwr      write qualifier (wins over moe)
//   moe      read qualifier
//   rd       read data, held until the next successful read
//   ack      one-cycle completion pulse
//   err      error flag, meaningful only while ack=1
//   busy     high whenever the responder is not in IDLE
//   acc_cnt  (DMR_ACC_CNT_EN only) saturating count of good completions
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int Mbit        = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic [Mbit-1:0] Adr,
    input  logic [Mbit-1:0] wrtData,
    input  logic            mwr,
    input  logic            moe,
    output logic [Mbit-1:0] rd,
    output logic            ack,
    output logic            err,
    output logic            busy
`ifdef DMR_ACC_CNT_EN
    ,
    output logic [15:0]     acc_cnt
`endif
);

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [Mbit-1:0] DEPTH_W = Mbit'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic [Mbit-1:0] adr_q,   adr_d;
    logic [Mbit-1:0] wdat_q,  wdat_d;
    logic            mwr_q,   mwr_d;
    logic            moe_q,   moe_d;
    logic [Mbit-1:0] rd_q,    rd_d;

    logic [Mbit-1:0] mem [DEPTH];

    // The access is resolved on the edge that enters RESP. With zero wait
    // states that edge is the capture edge itself, so the live inputs are used
    // instead of the (not yet loaded) capture registers.
    logic            capture;
    logic            enter_resp;
    logic [Mbit-1:0] acc_adr;
    logic [Mbit-1:0] acc_wdat;
    logic            acc_mwr;
    logic            acc_moe;
    logic            acc_err;
    logic [AW-1:0]   acc_idx;
    logic            mem_we;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        mwr_d      = mwr_q;
        moe_d      = moe_q;
        rd_d       = rd_q;
        enter_resp = 1'b0;

        capture  = (state_q == ST_IDLE) && req;
        acc_adr  = capture ? Adr     : adr_q;
        acc_wdat = capture ? wrtData : wdat_q;
        acc_mwr  = capture ? mwr     : mwr_q;
        acc_moe  = capture ? moe     : moe_q;
        acc_err  = (acc_adr[1:0] != 2'b00) || ((acc_adr >> 2) >= DEPTH_W);
        acc_idx  = acc_adr[AW+1:2];

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_d  = Adr;
                    wdat_d = wrtData;
                    mwr_d  = mwr;
                    moe_d  = moe;
                    cnt_d  = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d      = 4'd0;
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // mwr wins over moe; an erroring access touches neither storage nor rd.
        // Writes are gated by reset so a request held during reset cannot land.
        mem_we = enter_resp && acc_mwr && !acc_err && reset;
        if (enter_resp && !acc_mwr && acc_moe && !acc_err) begin
            rd_d = mem[acc_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            wdat_q  <= '0;
            mwr_q   <= 1'b0;
            moe_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            mwr_q   <= mwr_d;
            moe_q   <= moe_d;
            rd_q    <= rd_d;
        end
    end

    // NOTE: storage has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdat;
        end
    end

    assign ack  = (state_q == ST_RESP);
    assign err  = ack && acc_err;
    assign busy = (state_q != ST_IDLE);
    assign rd   = rd_q;

`ifdef DMR_ACC_CNT_EN
    logic [15:0] acc_cnt_q, acc_cnt_d;

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (ack && !err && (acc_cnt_q != 16'hFFFF)) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_cnt_q <= 16'd0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign acc_cnt = acc_cnt_q;
`endif

endmodule
